// File: rtl/midi_pkg.sv
// Shared MIDI definitions: transmitter state encoding, bit rate and status-byte ranges.
`timescale 1ns/1ps
package midi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    localparam int         MIDI_BAUD  = 31250;
    localparam logic [7:0] STATUS_MIN = 8'h80;
    localparam logic [7:0] CHAN_MAX   = 8'hEF;
    localparam logic [7:0] SYSCOM_MAX = 8'hF7;
    localparam logic [7:0] RT_MIN     = 8'hF8;

    // Channel-voice status bytes are the only ones eligible for running status.
    function automatic logic is_chan_status(input logic [7:0] b);
        return (b >= STATUS_MIN) && (b <= CHAN_MAX);
    endfunction

    function automatic logic is_syscom(input logic [7:0] b);
        return (b > CHAN_MAX) && (b <= SYSCOM_MAX);
    endfunction

endpackage

// File: rtl/midi_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses bitTick_o on the last count.
`timescale 1ns/1ps
module midi_baud_gen #(
    parameter int CLKS_PER_BIT = 320
) (
    input  logic clk_i,
    input  logic nrst_i,
    input  logic clr_i,
    output logic bitTick_o
);

    localparam int               CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]    LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d     = cnt_q + 1'b1;
        bitTick_o = (cnt_q == LAST) && !clr_i;
        if (clr_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/midi_tx.sv
// MIDI 8N1 serial transmitter with valid/ready byte input.
// Optional running-status compression enabled by defining MIDI_TX_RUNNING_STATUS_EN.
`timescale 1ns/1ps
module midi_tx
    import midi_pkg::*;
#(
    parameter int CLK_HZ = 10_000_000,
    parameter int BAUD   = MIDI_BAUD
) (
    input  logic       clk_i,
    input  logic       nrst_i,
    input  logic [7:0] txByte_i,
    input  logic       txValid_i,
    output logic       txReady_o,
    output logic       txData_o,
    output logic       busy_o,
    output logic       suppressed_o
);

    // Integer division; the configuration must leave at least 2 clocks per bit.
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

    tx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       txdata_q, txdata_d;
    logic       bit_tick;
    logic       xfer;
    logic       send;

    midi_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk_i    (clk_i),
        .nrst_i   (nrst_i),
        .clr_i    (state_q == IDLE),
        .bitTick_o(bit_tick)
    );

    assign txReady_o = (state_q == IDLE);
    assign busy_o    = (state_q != IDLE);
    assign txData_o  = txdata_q;
    assign xfer      = txValid_i && txReady_o;

`ifdef MIDI_TX_RUNNING_STATUS_EN
    logic [8:0] last_status_q, last_status_d;
    logic       suppressed_q, suppressed_d;

    always_comb begin
        last_status_d = last_status_q;
        suppressed_d  = 1'b0;
        send          = xfer;
        if (xfer) begin
            if (is_chan_status(txByte_i)) begin
                if (last_status_q == {1'b1, txByte_i}) begin
                    send         = 1'b0;
                    suppressed_d = 1'b1;
                end else begin
                    last_status_d = {1'b1, txByte_i};
                end
            end else if (is_syscom(txByte_i)) begin
                last_status_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            last_status_q <= '0;
            suppressed_q  <= 1'b0;
        end else begin
            last_status_q <= last_status_d;
            suppressed_q  <= suppressed_d;
        end
    end

    assign suppressed_o = suppressed_q;
`else
    assign send         = xfer;
    assign suppressed_o = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        case (state_q)
            IDLE: begin
                if (send) begin
                    state_d = START;
                    shift_d = txByte_i;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_tick) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // NOTE: the line is registered from the next state, so it is glitch-free and the start bit lands the cycle after transfer.
        case (state_d)
            START:   txdata_d = 1'b0;
            DATA:    txdata_d = shift_d[0];
            default: txdata_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            txdata_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            txdata_q  <= txdata_d;
        end
    end

endmodule
